// File: rtl/store_buffer_ctrl.sv
// Posted-write store buffer with in-order drain sequencer and load-hit detection.
// Optional store merging into the youngest entry is enabled by defining STORE_MERGE_EN.
module store_buffer_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [3:0]        st_wstrb,
    input  logic [31:0]       st_wdata,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_bvalid,
    output logic              empty,
    output logic              drained
);
    localparam int PW = $clog2(DEPTH);
    localparam int WA = ADDR_W - 2;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    state_e          state_q;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic [WA-1:0]   addr_q [DEPTH];
    logic [3:0]      strb_q [DEPTH];
    logic [31:0]     data_q [DEPTH];

    logic [WA-1:0]   st_word, ld_word;
    logic            full, accept, push, pop;
    logic [PW-1:0]   off;
    logic            unused_lsbs;

    assign st_word     = st_addr[ADDR_W-1:2];
    assign ld_word     = ld_addr[ADDR_W-1:2];
    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};
    assign full        = (count_q == FULL_CNT);

`ifdef STORE_MERGE_EN
    logic [PW-1:0] youngest;
    logic          merge_ok, merge;

    // The head may not be modified once its write has been presented to memory.
    assign youngest = tail_q - PW'(1);
    assign merge_ok = (count_q != '0) && (addr_q[youngest] == st_word)
                      && !((youngest == head_q) && (state_q != IDLE));
    assign st_ready = !full || merge_ok;
    assign accept   = st_valid && st_ready;
    assign merge    = accept && (st_wstrb != 4'b0000) && merge_ok;
    assign push     = accept && (st_wstrb != 4'b0000) && !merge_ok;
`else
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    assign push     = accept && (st_wstrb != 4'b0000);
`endif

    assign pop = (state_q == WAIT) && mem_bvalid;

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                IDLE:    if (count_q != '0) state_q <= SEND;
                SEND:    if (mem_ready) state_q <= WAIT;
                WAIT:    if (pop) state_q <= (count_d != '0) ? SEND : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_word;
            strb_q[tail_q] <= st_wstrb;
            data_q[tail_q] <= st_wdata;
        end
`ifdef STORE_MERGE_EN
        else if (merge) begin
            strb_q[youngest] <= strb_q[youngest] | st_wstrb;
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb[b]) data_q[youngest][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
`endif
    end

    // Only slots inside [head, head+count) are live; stale slots never hit.
    always_comb begin
        ld_hit = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if (({1'b0, off} < count_q) && (addr_q[i] == ld_word)) ld_hit = 1'b1;
        end
    end

    assign mem_valid = (state_q == SEND);
    assign mem_addr  = {addr_q[head_q], 2'b00};
    assign mem_wstrb = strb_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign empty     = (count_q == '0);
    assign drained   = empty && (state_q == IDLE);
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: expected memory writes go into a scoreboard queue,
// a monitor compares every accepted write request against it.
module tb_store_buffer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready;
    logic [31:0] st_addr;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_bvalid;
    logic        empty, drained;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    store_buffer_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wstrb(st_wstrb), .st_wdata(st_wdata),
        .ld_addr(ld_addr), .ld_hit(ld_hit),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_bvalid(mem_bvalid),
        .empty(empty), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_q.push_back({a, s, d});
    endtask

    task automatic send_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n;
        st_addr = a; st_wstrb = s; st_wdata = d; st_valid = 1'b1;
        #1;
        n = 0;
        while (!st_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL store_accept_timeout: addr 0x%0h never accepted", a);
        end
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain_one();
        int n;
        n = 0;
        while (!mem_valid && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL drain_timeout: mem_valid never rose, expected 1");
        end
        mem_ready = 1'b1;
        step();
        mem_ready  = 1'b0;
        mem_bvalid = 1'b1;
        step();
        mem_bvalid = 1'b0;
    endtask

    // Monitor: every accepted write request must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%0h, expected no write", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_strb", mem_wstrb, e.s);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; st_valid = 1'b0; st_addr = '0; st_wstrb = '0; st_wdata = '0;
        ld_addr = '0; mem_ready = 1'b0; mem_bvalid = 1'b0;
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_st_ready", st_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_empty", empty, 1);
        chk("rst_drained", drained, 1);
        rst_n = 1'b1;
        step();

        // Single store, latency and completion timing
        expect_wr(32'h100, 4'hF, 32'hDEADBEEF);
        send_store(32'h100, 4'hF, 32'hDEADBEEF);
        chk("t2_valid_acc1", mem_valid, 0);
        chk("t2_drained_busy", drained, 0);
        step();
        chk("t2_valid_acc2", mem_valid, 1);
        chk("t2_addr", mem_addr, 32'h100);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t2_valid_wait", mem_valid, 0);
        ld_addr = 32'h100;
        mem_bvalid = 1'b1;
        #1;
        chk("t2_hit_in_wait", ld_hit, 1);
        chk("t2_empty_wait", empty, 0);
        step();
        mem_bvalid = 1'b0;
        chk("t2_empty_after", empty, 1);
        chk("t2_drained_after", drained, 1);

        // Load hit detection
        ld_addr = 32'h204;
        st_addr = 32'h204; st_wstrb = 4'h1; st_wdata = 32'hAA; st_valid = 1'b1;
        #1;
        chk("t4_hit_accept_cycle", ld_hit, 0);
        expect_wr(32'h204, 4'h1, 32'hAA);
        send_store(32'h204, 4'h1, 32'hAA);
        ld_addr = 32'h207;
        #1;
        chk("t4_hit_207", ld_hit, 1);
        ld_addr = 32'h208;
        #1;
        chk("t4_hit_208", ld_hit, 0);
        drain_one();
        ld_addr = 32'h204;
        #1;
        chk("t4_hit_after_drain", ld_hit, 0);

        // Zero strobe store is consumed and dropped
        send_store(32'h400, 4'h0, 32'h55555555);
        chk("t5_empty", empty, 1);
        step(); step();
        chk("t5_no_req", mem_valid, 0);
        chk("t5_drained", drained, 1);

        // Fill, stall a fifth store, release after the first pop
        for (int i = 0; i < 5; i++) expect_wr(32'h500 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h500 + 32'(4*i); st_wstrb = 4'hF; st_wdata = 32'hA0000000 + 32'(i);
            st_valid = 1'b1;
            #1;
            chk("t3_ready_fill", st_ready, 1);
            step();
        end
        st_addr = 32'h510; st_wdata = 32'hA0000004;
        #1;
        chk("t3_ready_full", st_ready, 0);
        step(); step();
        chk("t3_ready_held", st_ready, 0);
        chk("t3_head_valid", mem_valid, 1);
        chk("t3_head_addr", mem_addr, 32'h500);
        mem_ready = 1'b1;
        step();
        mem_ready  = 1'b0;
        mem_bvalid = 1'b1;
        #1;
        chk("t3_ready_pop_cycle", st_ready, 0);
        step();
        mem_bvalid = 1'b0;
        #1;
        chk("t3_ready_after_pop", st_ready, 1);
        step();
        st_valid = 1'b0;
        chk("t3_not_empty", empty, 0);
        for (int i = 0; i < 4; i++) drain_one();
        chk("t3_empty_end", empty, 1);

        // Reset in the middle of a drain
        expect_wr(32'h600, 4'hF, 32'hB0);
        send_store(32'h600, 4'hF, 32'hB0);
        send_store(32'h604, 4'hF, 32'hB1);
        chk("t1_send", mem_valid, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t1_wait_valid", mem_valid, 0);
        chk("t1_wait_empty", empty, 0);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", mem_valid, 0);
        chk("t1_rst_empty", empty, 1);
        chk("t1_rst_drained", drained, 1);
        chk("t1_rst_ready", st_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        mem_bvalid = 1'b1;
        step();
        mem_bvalid = 1'b0;
        chk("t1_bvalid_ignored_empty", empty, 1);
        chk("t1_bvalid_ignored_drained", drained, 1);
        ld_addr = 32'h600;
        #1;
        chk("t1_stale_no_hit", ld_hit, 0);
        step();
        chk("t1_no_req", mem_valid, 0);

        // Merge into youngest entry while the head is busy with another word
        expect_wr(32'h700, 4'hF, 32'h12345678);
        send_store(32'h700, 4'hF, 32'h12345678);
        step();
        chk("t6_head_send", mem_valid, 1);
        expect_wr(32'h700, 4'h4, 32'h00330000);
        send_store(32'h700, 4'h4, 32'h00330000);
        send_store(32'h300, 4'h1, 32'h00000011);
        send_store(32'h301, 4'h2, 32'h00002200);
`ifdef STORE_MERGE_EN
        expect_wr(32'h300, 4'h3, 32'h00002211);
        for (int i = 0; i < 3; i++) drain_one();
`else
        expect_wr(32'h300, 4'h1, 32'h00000011);
        expect_wr(32'h300, 4'h2, 32'h00002200);
        for (int i = 0; i < 4; i++) drain_one();
`endif
        step();
        chk("t6_empty_end", empty, 1);
        chk("t6_drained_end", drained, 1);
        chk("all_writes_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
